// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : aes_key_sched_ctrl
//  Purpose : Sequences the single-round GenKey unit through the AES key
//            expansion and streams round keys 0..NUM_ROUNDS to the datapath.
//            Optional round-key buffer: define AES_KEY_SCHED_RKBUF_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module aes_key_sched_ctrl #(
    parameter int KEY_LEN    = 128,
    parameter int WORD_LEN   = 32,
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [KEY_LEN-1:0]  key_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                gk_valid_in,
    output logic [KEY_LEN-1:0]  gk_key_in,
    output logic [WORD_LEN-1:0] gk_rcon,
    input  logic [KEY_LEN-1:0]  gk_round_key,
    input  logic                gk_valid_out,
    output logic                rk_valid,
    output logic [3:0]          rk_idx,
    output logic [KEY_LEN-1:0]  rk_data
`ifdef AES_KEY_SCHED_RKBUF_EN
    ,
    input  logic [3:0]          rb_addr,
    output logic [KEY_LEN-1:0]  rb_data
`endif
);

    localparam int              c_TW    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      c_LAST  = 4'(NUM_ROUNDS);
    localparam logic [c_TW-1:0] c_TMAX  = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_TONE  = c_TW'(1);
    localparam logic [7:0]      c_RCON0 = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_round;
    logic [7:0]      r_rcon;
    logic [c_TW-1:0] r_timer;
    logic [7:0]      w_rcon_next;

    // xtime in GF(2^8): the next Rcon value
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_round     <= 4'd0;
            r_rcon      <= c_RCON0;
            r_timer     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            gk_valid_in <= 1'b0;
            gk_key_in   <= '0;
            gk_rcon     <= '0;
            rk_valid    <= 1'b0;
            rk_idx      <= 4'd0;
            rk_data     <= '0;
        end else begin
            gk_valid_in <= 1'b0;
            rk_valid    <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Round key 0 is the cipher key itself; the first request goes out alongside it
                        if (start) begin
                            busy        <= 1'b1;
                            err         <= 1'b0;
                            r_round     <= 4'd1;
                            r_rcon      <= c_RCON0;
                            rk_valid    <= 1'b1;
                            rk_idx      <= 4'd0;
                            rk_data     <= key_in;
                            gk_valid_in <= 1'b1;
                            gk_key_in   <= key_in;
                            gk_rcon     <= {c_RCON0, {(WORD_LEN-8){1'b0}}};
                            r_state     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (gk_valid_out) begin
                            rk_valid <= 1'b1;
                            rk_idx   <= r_round;
                            rk_data  <= gk_round_key;
                            if (r_round == c_LAST) begin
                                r_state <= S_DONE;
                            end else begin
                                r_round     <= r_round + 4'd1;
                                r_rcon      <= w_rcon_next;
                                gk_valid_in <= 1'b1;
                                gk_key_in   <= gk_round_key;
                                gk_rcon     <= {w_rcon_next, {(WORD_LEN-8){1'b0}}};
                                r_state     <= S_ISSUE;
                            end
                        end else if (r_timer == c_TMAX) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + c_TONE;
                        end
                    end
                    S_DONE: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef AES_KEY_SCHED_RKBUF_EN
    logic [KEY_LEN-1:0] r_rkbuf [0:NUM_ROUNDS];

    // Buffer contents survive reset so a host can still read the last schedule
    always_ff @(posedge clk) begin
        if (rk_valid) begin
            r_rkbuf[rk_idx] <= rk_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_data <= '0;
        end else begin
            rb_data <= (rb_addr <= c_LAST) ? r_rkbuf[rb_addr] : '0;
        end
    end
`endif

endmodule
`default_nettype wire
